// File: rtl/weight_update_ctrl.sv
// weight_update_ctrl
// ------------------
// Training sequencer for the backpropagation network. A run loads the initial
// weights once, then for every sample of every epoch launches a forward pass,
// waits for it, launches a backward pass, waits for it, and commits the delta
// weights.
//
// Handshake semantics (all Moore, no combinational input-to-output path):
//   start   : level, sampled on the rising edge; honoured only in IDLE/DONE.
//   ff_start: one-cycle launch pulse; ff_done acts as the forward "valid"
//             and is sampled only while waiting in FF_WAIT.
//   bp_start: one-cycle launch pulse; bp_done acts as the backward "valid"
//             and is sampled only while waiting in BP_WAIT.
//   abort   : synchronous, beats every other input outside IDLE.
//
// Ports
//   clk            : clock, rising edge
//   reset          : asynchronous active-low reset
//   start, abort   : run control
//   ff_done        : forward pass complete
//   bp_done        : delta weights valid
//   select_initial : weight registers load initial values (INIT)
//   select_update  : weight registers add delta weights (UPDATE)
//   ff_start       : forward pass launch pulse (FF_START)
//   bp_start       : backward pass launch pulse (BP_START)
//   sample_idx     : current training-sample index
//   epoch_cnt      : completed epochs
//   busy           : high outside IDLE and DONE
//   done           : high in DONE
//   dbg_state      : encoded FSM state for observation
module weight_update_ctrl #(
  parameter int N_SAMPLES = 4,
  parameter int N_EPOCHS  = 1000,
  parameter int SAMPLE_W  = 2,
  parameter int EPOCH_W   = 10
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                abort,
  input  logic                ff_done,
  input  logic                bp_done,
  output logic                select_initial,
  output logic                select_update,
  output logic                ff_start,
  output logic                bp_start,
  output logic [SAMPLE_W-1:0] sample_idx,
  output logic [EPOCH_W-1:0]  epoch_cnt,
  output logic                busy,
  output logic                done,
  output logic [2:0]          dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_INIT     = 3'd1,
    S_FF_START = 3'd2,
    S_FF_WAIT  = 3'd3,
    S_BP_START = 3'd4,
    S_BP_WAIT  = 3'd5,
    S_UPDATE   = 3'd6,
    S_DONE     = 3'd7
  } state_t;

  localparam logic [SAMPLE_W-1:0] LP_LAST_SAMPLE = SAMPLE_W'(N_SAMPLES - 1);
  localparam logic [EPOCH_W-1:0]  LP_LAST_EPOCH  = EPOCH_W'(N_EPOCHS - 1);

  state_t              r_state;
  logic [SAMPLE_W-1:0] r_sample_idx;
  logic [EPOCH_W-1:0]  r_epoch_cnt;

  state_t              w_next_state;
  logic [SAMPLE_W-1:0] w_next_sample;
  logic [EPOCH_W-1:0]  w_next_epoch;
  logic                w_last_sample;

  assign w_last_sample = (r_sample_idx == LP_LAST_SAMPLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_sample_idx <= '0;
      r_epoch_cnt  <= '0;
    end else begin
      r_state      <= w_next_state;
      r_sample_idx <= w_next_sample;
      r_epoch_cnt  <= w_next_epoch;
    end
  end

  always_comb begin
    w_next_state  = r_state;
    w_next_sample = r_sample_idx;
    w_next_epoch  = r_epoch_cnt;
    if (abort && (r_state != S_IDLE)) begin
      w_next_state  = S_IDLE;
      w_next_sample = '0;
      w_next_epoch  = '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            w_next_state  = S_INIT;
            w_next_sample = '0;
            w_next_epoch  = '0;
          end
        end
        S_INIT:     w_next_state = S_FF_START;
        S_FF_START: w_next_state = S_FF_WAIT;
        S_FF_WAIT:  if (ff_done) w_next_state = S_BP_START;
        S_BP_START: w_next_state = S_BP_WAIT;
        S_BP_WAIT:  if (bp_done) w_next_state = S_UPDATE;
        S_UPDATE: begin
          // Counters advance only when leaving UPDATE, so sample_idx is
          // stable for the whole forward/backward/update of one sample.
          if (w_last_sample) begin
            w_next_sample = '0;
            w_next_epoch  = r_epoch_cnt + 1'b1;
          end else begin
            w_next_sample = r_sample_idx + 1'b1;
          end
          if (w_last_sample && (r_epoch_cnt == LP_LAST_EPOCH)) begin
            w_next_state = S_DONE;
          end else begin
            w_next_state = S_FF_START;
          end
        end
        default: w_next_state = S_IDLE;
      endcase
    end
  end

  assign select_initial = (r_state == S_INIT);
  assign select_update  = (r_state == S_UPDATE);
  assign ff_start       = (r_state == S_FF_START);
  assign bp_start       = (r_state == S_BP_START);
  assign done           = (r_state == S_DONE);
  assign busy           = (r_state != S_IDLE) && (r_state != S_DONE);
  assign sample_idx     = r_sample_idx;
  assign epoch_cnt      = r_epoch_cnt;
  assign dbg_state      = r_state;

endmodule

// File: tb/tb_weight_update_ctrl.sv
// Directed bench for weight_update_ctrl with N_SAMPLES=4, N_EPOCHS=2.
module tb_weight_update_ctrl;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_INIT    = 3'd1;
  localparam logic [2:0] ST_FF_WAIT = 3'd3;
  localparam logic [2:0] ST_BP_WAIT = 3'd5;
  localparam logic [2:0] ST_DONE    = 3'd7;

  logic       clk;
  logic       reset;
  logic       start;
  logic       abort;
  logic       ff_done;
  logic       bp_done;
  logic       select_initial;
  logic       select_update;
  logic       ff_start;
  logic       bp_start;
  logic [1:0] sample_idx;
  logic [9:0] epoch_cnt;
  logic       busy;
  logic       done;
  logic [2:0] dbg_state;
  logic [5:0] outs;

  int checks   = 0;
  int failures = 0;
  logic [1:0] exp_q[$];

  weight_update_ctrl #(
    .N_SAMPLES(4),
    .N_EPOCHS (2),
    .SAMPLE_W (2),
    .EPOCH_W  (10)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .abort         (abort),
    .ff_done       (ff_done),
    .bp_done       (bp_done),
    .select_initial(select_initial),
    .select_update (select_update),
    .ff_start      (ff_start),
    .bp_start      (bp_start),
    .sample_idx    (sample_idx),
    .epoch_cnt     (epoch_cnt),
    .busy          (busy),
    .done          (done),
    .dbg_state     (dbg_state)
  );

  assign outs = {select_initial, select_update, ff_start, bp_start, busy, done};

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Entered in the INIT cycle of a run with ff_done=bp_done=1. Runs to DONE
  // and checks cycle count, pulse counts and the sample index sequence.
  task automatic run_nominal(input int stray_at);
    int n;
    int n_init;
    int n_upd;
    int last_upd;
    n = 0; n_init = 0; n_upd = 0; last_upd = -1;
    exp_q = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
    while (!done && n < 100) begin
      if (n == stray_at) start = 1'b1;
      tick();
      start = 1'b0;
      n++;
      if (select_initial) n_init++;
      if (select_update) begin
        n_upd++;
        last_upd = n;
        if (exp_q.size() == 0) chk("nom_extra_update", 32'd1, 32'd0);
        else chk("nom_update_idx", 32'(sample_idx), 32'(exp_q.pop_front()));
      end
    end
    chk("nom_done_latency", 32'(n), 32'd41);
    chk("nom_init_pulses", 32'(n_init), 32'd0);
    chk("nom_update_pulses", 32'(n_upd), 32'd8);
    chk("nom_last_update", 32'(last_upd), 32'd40);
    chk("nom_done_epoch", 32'(epoch_cnt), 32'd2);
    chk("nom_done_idx", 32'(sample_idx), 32'd0);
    chk("nom_done_outs", 32'(outs), 32'b000001);
  endtask

  // Entered in an FF_START cycle; forward wait 3 extra cycles, backward wait
  // 5 extra cycles, one stray ff_done during BP_WAIT. Returns the cycles
  // until the next FF_START.
  task automatic var_sample(output int cyc);
    cyc = 0;
    chk("var_ff_start", 32'(ff_start), 32'd1);
    repeat (4) begin
      tick(); cyc++;
      chk("var_ff_wait_state", 32'(dbg_state), 32'(ST_FF_WAIT));
      chk("var_ff_wait_outs", 32'({ff_start, bp_start, select_update}), 32'd0);
    end
    ff_done = 1'b1;
    tick(); cyc++;
    ff_done = 1'b0;
    chk("var_bp_start", 32'(bp_start), 32'd1);
    for (int i = 0; i < 6; i++) begin
      tick(); cyc++;
      ff_done = (i == 1);
      chk("var_bp_wait_state", 32'(dbg_state), 32'(ST_BP_WAIT));
      chk("var_no_early_update", 32'(select_update), 32'd0);
    end
    ff_done = 1'b0;
    bp_done = 1'b1;
    tick(); cyc++;
    bp_done = 1'b0;
    chk("var_update", 32'(select_update), 32'd1);
    tick(); cyc++;
    chk("var_next_ff_start", 32'(ff_start), 32'd1);
  endtask

  initial begin
    int cyc;
    reset = 1'b0; start = 1'b0; abort = 1'b0; ff_done = 1'b0; bp_done = 1'b0;

    // Reset held for 3 cycles
    #1;
    repeat (3) begin
      chk("rst_outs", 32'(outs), 32'd0);
      chk("rst_counters", 32'({sample_idx, epoch_cnt}), 32'd0);
      chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));
      tick();
    end
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ff_done = i[0];
      bp_done = ~i[0];
      abort   = (i == 2);
      tick();
      chk("idle_ignore_state", 32'(dbg_state), 32'(ST_IDLE));
      chk("idle_ignore_outs", 32'(outs), 32'd0);
    end
    abort = 1'b0;

    // Nominal run, immediate done
    ff_done = 1'b1; bp_done = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("nom_init_outs", 32'(outs), 32'b100010);
    chk("nom_init_counters", 32'({sample_idx, epoch_cnt}), 32'd0);
    run_nominal(-1);
    repeat (3) begin
      tick();
      chk("done_hold_state", 32'(dbg_state), 32'(ST_DONE));
      chk("done_hold_counters", 32'({sample_idx, epoch_cnt}), 32'({2'd0, 10'd2}));
    end

    // Restart from DONE with ff_done high; stray start mid-run
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("restart_outs", 32'(outs), 32'b100010);
    chk("restart_epoch", 32'(epoch_cnt), 32'd0);
    chk("restart_idx", 32'(sample_idx), 32'd0);
    run_nominal(10);

    // Variable handshake latency
    ff_done = 1'b0; bp_done = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("var_init_state", 32'(dbg_state), 32'(ST_INIT));
    tick();
    var_sample(cyc);
    chk("var_period_s0", 32'(cyc), 32'd13);
    chk("var_idx_s1", 32'(sample_idx), 32'd1);
    var_sample(cyc);
    chk("var_period_s1", 32'(cyc), 32'd13);
    chk("var_idx_s2", 32'(sample_idx), 32'd2);

    // Abort in BP_WAIT of sample 2, epoch 0 (bp_done high at the same edge)
    ff_done = 1'b1;
    tick();
    tick();
    ff_done = 1'b0;
    tick();
    chk("abort_pre_state", 32'(dbg_state), 32'(ST_BP_WAIT));
    abort = 1'b1; bp_done = 1'b1;
    tick();
    abort = 1'b0; bp_done = 1'b0;
    chk("abort_state", 32'(dbg_state), 32'(ST_IDLE));
    chk("abort_outs", 32'(outs), 32'd0);
    chk("abort_counters", 32'({sample_idx, epoch_cnt}), 32'd0);
    tick();
    chk("abort_stays_idle", 32'(outs), 32'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("abort_restart", 32'(outs), 32'b100010);

    // Async reset during UPDATE
    ff_done = 1'b1; bp_done = 1'b1;
    repeat (5) tick();
    chk("arst_pre_update", 32'(select_update), 32'd1);
    #3;
    reset = 1'b0;
    #1;
    chk("arst_update_drop", 32'(outs), 32'd0);
    chk("arst_state", 32'(dbg_state), 32'(ST_IDLE));
    chk("arst_counters", 32'({sample_idx, epoch_cnt}), 32'd0);
    tick();
    reset = 1'b1;
    ff_done = 1'b0; bp_done = 1'b0;
    tick();
    chk("arst_after_release", 32'(dbg_state), 32'(ST_IDLE));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/weight_update_ctrl.md
# weight_update_ctrl

Training sequencer for the backpropagation network. It loads the initial weights into every weight register, then steps through the training set for a fixed number of epochs. For each sample it runs a forward pass, then a backward pass, then commits the delta weights. Its `select_initial` and `select_update` outputs drive the identically named inputs of every weight-register block in parallel. Its `ff_start`/`ff_done` and `bp_start`/`bp_done` handshakes sequence the forward and backward datapaths.

## Interface

Parameters:
- `N_SAMPLES`, default 4: training samples per epoch; legal range 1..2^`SAMPLE_W`.
- `N_EPOCHS`, default 1000: epochs per training run; legal range 1..2^`EPOCH_W`-1.
- `SAMPLE_W`, default 2: width of `sample_idx`.
- `EPOCH_W`, default 10: width of `epoch_cnt`.

Ports:
- `clk`, input, 1: single clock; all state changes on the rising edge.
- `reset`, input, 1: asynchronous, active-low (0 = reset). Asserts immediately; deassertion is synchronous to `clk` upstream.
- `start`, input, 1: begin a training run; honoured only in IDLE or DONE.
- `abort`, input, 1: synchronous stop; return to IDLE.
- `ff_done`, input, 1: forward pass complete; honoured only in FF_WAIT.
- `bp_done`, input, 1: delta weights valid; honoured only in BP_WAIT.
- `select_initial`, output, 1: weight registers load their initial values.
- `select_update`, output, 1: weight registers add their delta weight.
- `ff_start`, output, 1: one-cycle pulse that launches the forward pass.
- `bp_start`, output, 1: one-cycle pulse that launches the backward pass.
- `sample_idx`, output, `SAMPLE_W`: current training-sample index; the input/target mux uses it.
- `epoch_cnt`, output, `EPOCH_W`: number of completed epochs.
- `busy`, output, 1: high in every state except IDLE and DONE.
- `done`, output, 1: high in DONE.

## Operation

- States: IDLE, INIT, FF_START, FF_WAIT, BP_START, BP_WAIT, UPDATE, DONE.
- Moore machine: every output is a function of the registered state and counters only. No input reaches an output combinationally.
- Output decode:
  - INIT: `select_initial` = 1.
  - FF_START: `ff_start` = 1.
  - BP_START: `bp_start` = 1.
  - UPDATE: `select_update` = 1.
  - DONE: `done` = 1.
  - `select_initial` and `select_update` are never high together.
- Transitions, highest priority first:
  - `abort`=1 in any state except IDLE: go to IDLE and clear both counters. This overrides `start`, `ff_done` and `bp_done`.
  - IDLE or DONE with `start`=1: go to INIT and clear both counters.
  - INIT: go to FF_START.
  - FF_START: go to FF_WAIT.
  - FF_WAIT: go to BP_START on `ff_done`, otherwise hold.
  - BP_START: go to BP_WAIT.
  - BP_WAIT: go to UPDATE on `bp_done`, otherwise hold.
  - UPDATE, last sample of the last epoch: go to DONE.
  - UPDATE, any other sample: go to FF_START.
- Last sample of the last epoch means `sample_idx`=`N_SAMPLES`-1 and `epoch_cnt`=`N_EPOCHS`-1.
- Counters update only on the edge that leaves UPDATE:
  - `sample_idx` wraps from `N_SAMPLES`-1 to 0; otherwise it increments by 1.
  - `epoch_cnt` increments by 1 when `sample_idx` wraps.
  - On entry to DONE, `sample_idx` = 0 and `epoch_cnt` = `N_EPOCHS`.
- Ignored inputs:
  - `start` in any state other than IDLE or DONE.
  - `ff_done` outside FF_WAIT.
  - `bp_done` outside BP_WAIT.
- DONE holds, with `done`=1 and both counters frozen, until `start`, `abort` or `reset`.
- `abort` in IDLE has no effect.

## Timing

- Reset (`reset`=0):
  - State = IDLE, both counters = 0.
  - All 1-bit outputs = 0.
  - Takes effect asynchronously, including mid-run. A reset during UPDATE suppresses the update because `select_update` drops at once.
- Start latency: `start` sampled at edge k gives `select_initial` high for exactly the cycle between edges k and k+1.
- Each pulse output (`ff_start`, `bp_start`, `select_initial`, `select_update`) lasts exactly one cycle.
- `sample_idx` is stable from FF_START through UPDATE of each sample.
- Per-sample cost is 5 + Wf + Wb cycles:
  - Wf counts the extra FF_WAIT cycles before `ff_done`; Wb counts the extra BP_WAIT cycles before `bp_done`.
  - `ff_done` or `bp_done` already high on the first wait cycle gives zero wait.
- Full-run cost with zero wait: 1 + 5·`N_SAMPLES`·`N_EPOCHS` cycles from the `start` edge to DONE entry.
- `done` rises one cycle after the last `select_update` cycle.
- `start` in DONE:
  - `done` falls and `select_initial` rises in the same cycle.
  - The counters read 0 in that cycle.

## Test plan

- **Reset:** pulse `reset` low for 3 cycles, then release. Required: all outputs 0, `sample_idx`=0, `epoch_cnt`=0, state IDLE throughout. `ff_done`/`bp_done` toggling in IDLE changes nothing.
- **Nominal run, immediate done:** `N_SAMPLES`=4, `N_EPOCHS`=2, `ff_done`=`bp_done`=1. Pulse `start`. Required:
  - Exactly 1 `select_initial` pulse, then 8 `select_update` pulses, with `sample_idx` sequence 0,1,2,3,0,1,2,3.
  - `done` rises 41 cycles after the `start` edge, with `epoch_cnt`=2.
- **Variable handshake latency:** `ff_done` 3 cycles after `ff_start`, `bp_done` 5 cycles after `bp_start`. Required:
  - Per-sample period is 13 cycles.
  - A stray `ff_done` pulse during BP_WAIT is ignored.
  - No `select_update` before `bp_done`.
- **Abort mid-run:** assert `abort` in BP_WAIT of sample 2, epoch 0. Required: next cycle IDLE, `busy`=0, counters 0, no `select_update` issued. A following `start` begins again with `select_initial`.
- **Async reset during UPDATE:** drop `reset` mid-cycle while `select_update`=1. Required: `select_update` falls before the next edge and the state is IDLE.
- **Restart from DONE:** after a completed run, assert `start` together with `ff_done`=1. Required: `done` falls, `select_initial` pulses once, `epoch_cnt`=0, and the run repeats identically. A `start` asserted during the run is ignored.
